// File: rtl/id_hazard_sequencer_pkg.sv
// Shared types and constants for the ID-stage hazard sequencer.
// Holds the sequencer state encoding, default parameters and the
// register-match helper used by the hazard need calculation.
package id_hazard_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam int DRAIN_CYCLES_DEF = 4;
    localparam int CNT_W_DEF        = 32;

    localparam logic [1:0] NEED_NONE = 2'd0;
    localparam logic [1:0] NEED_ONE  = 2'd1;
    localparam logic [1:0] NEED_TWO  = 2'd2;

    // A producer destination hits the ID consumer when it names rs, or rt
    // when the instruction actually reads rt. $0 is hardwired and never hits.
    function automatic logic src_match(input logic [4:0] dst,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic       uses_rt);
        return (dst != 5'd0) && ((dst == rs) || (uses_rt && (dst == rt)));
    endfunction

endpackage

// File: rtl/id_hazard_sequencer_if.sv
// Handshake bundle between the pipeline datapath and the hazard sequencer.
// master: the pipeline side driving ID/EX/MEM info and consuming controls.
// slave:  the sequencer.
interface id_hazard_sequencer_if #(
    parameter int CNT_W = 32
) ();
    logic             enable;
    logic [4:0]       if_id_rs;
    logic [4:0]       if_id_rt;
    logic             if_id_is_branch;
    logic             if_id_uses_rt;
    logic             if_id_halt;
    logic             branch_taken;
    logic [4:0]       id_ex_rt;
    logic [4:0]       id_ex_rd_dst;
    logic             id_ex_mem_read;
    logic             id_ex_reg_write;
    logic [4:0]       ex_m_rd;
    logic             ex_m_mem_read;

    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output enable, if_id_rs, if_id_rt, if_id_is_branch, if_id_uses_rt,
               if_id_halt, branch_taken, id_ex_rt, id_ex_rd_dst,
               id_ex_mem_read, id_ex_reg_write, ex_m_rd, ex_m_mem_read,
        input  pc_write, if_id_write, id_ex_bubble, if_id_flush, halted,
               stall_count
    );

    modport slave (
        input  enable, if_id_rs, if_id_rt, if_id_is_branch, if_id_uses_rt,
               if_id_halt, branch_taken, id_ex_rt, id_ex_rd_dst,
               id_ex_mem_read, id_ex_reg_write, ex_m_rd, ex_m_mem_read,
        output pc_write, if_id_write, id_ex_bubble, if_id_flush, halted,
               stall_count
    );
endinterface

// File: rtl/id_hazard_sequencer_need_calc.sv
// Combinational hazard need for the instruction sitting in ID.
// need=2: branch waiting on a load still in EX (two bubbles).
// need=1: load-use in EX, or branch waiting on an ALU result in EX or a
//         load in EX/MEM (one bubble, re-evaluated next cycle).
module hazard_need_calc
    import id_hazard_sequencer_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rt,
    input  logic       i_uses_rt,
    input  logic       i_is_branch,
    input  logic [4:0] i_id_ex_rt,
    input  logic [4:0] i_id_ex_rd_dst,
    input  logic       i_id_ex_mem_read,
    input  logic       i_id_ex_reg_write,
    input  logic [4:0] i_ex_m_rd,
    input  logic       i_ex_m_mem_read,
    output logic [1:0] o_need
);
    logic w_ex_load_hit;
    logic w_ex_alu_hit;
    logic w_m_load_hit;

    assign w_ex_load_hit = i_id_ex_mem_read  && src_match(i_id_ex_rt,     i_rs, i_rt, i_uses_rt);
    assign w_ex_alu_hit  = i_id_ex_reg_write && src_match(i_id_ex_rd_dst, i_rs, i_rt, i_uses_rt);
    assign w_m_load_hit  = i_ex_m_mem_read   && src_match(i_ex_m_rd,      i_rs, i_rt, i_uses_rt);

    // Priority-ordered hazard classification
    always_comb begin
        o_need = NEED_NONE;
        if (i_is_branch && w_ex_load_hit)
            o_need = NEED_TWO;
        else if (w_ex_load_hit)
            o_need = NEED_ONE;
        else if (i_is_branch && w_ex_alu_hit)
            o_need = NEED_ONE;
        else if (i_is_branch && w_m_load_hit)
            o_need = NEED_ONE;
    end
endmodule

// File: rtl/id_hazard_sequencer.sv
// ID-stage hazard sequencer: stalls on load-use and branch-in-ID hazards,
// flushes IF/ID on taken branches, and drains the pipeline on halt.
// Control outputs are combinational from state and ID/EX info so a stall
// or flush takes effect in the same cycle the hazard is seen.
// Optional macro HAZARD_PERF_CNT_EN builds a saturating stall counter;
// without it stall_count is tied to zero.
module id_hazard_sequencer
    import id_hazard_sequencer_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    id_hazard_sequencer_if.slave  bus
);
    localparam int CNT_BITS = $clog2(DRAIN_CYCLES + 1);

    state_t              r_state;
    logic [CNT_BITS-1:0] r_cnt;
    logic [1:0]          w_need_raw;
    logic [1:0]          w_need;
    logic                w_stall;
    logic [CNT_W-1:0]    w_stall_count;

    hazard_need_calc u_need (
        .i_rs              (bus.if_id_rs),
        .i_rt              (bus.if_id_rt),
        .i_uses_rt         (bus.if_id_uses_rt),
        .i_is_branch       (bus.if_id_is_branch),
        .i_id_ex_rt        (bus.id_ex_rt),
        .i_id_ex_rd_dst    (bus.id_ex_rd_dst),
        .i_id_ex_mem_read  (bus.id_ex_mem_read),
        .i_id_ex_reg_write (bus.id_ex_reg_write),
        .i_ex_m_rd         (bus.ex_m_rd),
        .i_ex_m_mem_read   (bus.ex_m_mem_read),
        .o_need            (w_need_raw)
    );

    // Hazards only matter while the front end is free-running
    assign w_need = (r_state == ST_RUN) ? w_need_raw : NEED_NONE;

    // Same-cycle control decode; reset dominates, then the enable freeze
    always_comb begin
        bus.pc_write     = 1'b0;
        bus.if_id_write  = 1'b0;
        bus.id_ex_bubble = 1'b0;
        bus.if_id_flush  = 1'b0;
        w_stall          = 1'b0;
        if (reset) begin
            bus.id_ex_bubble = 1'b1;
        end else if (bus.enable) begin
            case (r_state)
                ST_RUN: begin
                    if (w_need != NEED_NONE) begin
                        // stall wins over both branch flush and halt
                        bus.id_ex_bubble = 1'b1;
                        w_stall          = 1'b1;
                    end else if (bus.if_id_halt) begin
                        // halt moves on to EX; squash whatever was fetched behind it
                        bus.if_id_flush  = 1'b1;
                    end else begin
                        bus.pc_write     = 1'b1;
                        bus.if_id_write  = 1'b1;
                        bus.if_id_flush  = bus.if_id_is_branch && bus.branch_taken;
                    end
                end
                ST_STALL: begin
                    bus.id_ex_bubble = 1'b1;
                    w_stall          = 1'b1;
                end
                default: begin
                    // DRAIN and HALTED keep the front end parked
                    bus.id_ex_bubble = 1'b1;
                end
            endcase
        end
    end

    assign bus.halted = !reset && (r_state == ST_HALTED);

    // Sequencer FSM: multi-cycle stall and drain countdowns
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else if (bus.enable) begin
            case (r_state)
                ST_RUN: begin
                    if (w_need == NEED_TWO) begin
                        r_state <= ST_STALL;
                        r_cnt   <= CNT_BITS'(1);
                    end else if ((w_need == NEED_NONE) && bus.if_id_halt) begin
                        // a one-cycle drain goes straight to HALTED
                        r_state <= (DRAIN_CYCLES <= 1) ? ST_HALTED : ST_DRAIN;
                        r_cnt   <= CNT_BITS'(DRAIN_CYCLES - 1);
                    end
                end
                ST_STALL: begin
                    if (r_cnt <= CNT_BITS'(1)) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt - CNT_BITS'(1);
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt <= CNT_BITS'(1)) begin
                        r_state <= ST_HALTED;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt - CNT_BITS'(1);
                    end
                end
                default: begin
                    r_state <= ST_HALTED;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_count;

    // Count enabled stall cycles, sticking at all-ones
    always_ff @(posedge clk) begin
        if (reset)
            r_stall_count <= '0;
        else if (w_stall && (r_stall_count != {CNT_W{1'b1}}))
            r_stall_count <= r_stall_count + CNT_W'(1);
    end

    assign w_stall_count = reset ? '0 : r_stall_count;
`else
    logic w_unused_stall;
    assign w_unused_stall = w_stall;
    assign w_stall_count  = '0;
`endif

    assign bus.stall_count = w_stall_count;

endmodule

// File: tb/tb_id_hazard_sequencer.sv
// Directed bench for id_hazard_sequencer. Each step drives ID/EX/MEM info on
// the falling edge, queues the expected control vector, and compares it a
// moment later, before the next rising edge commits state.
// Expected vector order: {pc_write, if_id_write, id_ex_bubble, if_id_flush, halted}.
module tb_id_hazard_sequencer;

    localparam logic [4:0] V_RUN    = 5'b11000;
    localparam logic [4:0] V_STALL  = 5'b00100;
    localparam logic [4:0] V_RST    = 5'b00100;
    localparam logic [4:0] V_FLUSH  = 5'b11010;
    localparam logic [4:0] V_HFL    = 5'b00010;
    localparam logic [4:0] V_DRAIN  = 5'b00100;
    localparam logic [4:0] V_HALTED = 5'b00101;
    localparam logic [4:0] V_OFF    = 5'b00000;
    localparam logic [4:0] V_OFFH   = 5'b00001;

    typedef struct packed {
        logic [4:0]  v;
        logic [31:0] sc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   exp_sc = 0;
    exp_t q[$];

    id_hazard_sequencer_if #(.CNT_W(32)) bus ();

    id_hazard_sequencer #(.DRAIN_CYCLES(4), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic clr();
        bus.if_id_rs        = 5'd0;
        bus.if_id_rt        = 5'd0;
        bus.if_id_is_branch = 1'b0;
        bus.if_id_uses_rt   = 1'b0;
        bus.if_id_halt      = 1'b0;
        bus.branch_taken    = 1'b0;
        bus.id_ex_rt        = 5'd0;
        bus.id_ex_rd_dst    = 5'd0;
        bus.id_ex_mem_read  = 1'b0;
        bus.id_ex_reg_write = 1'b0;
        bus.ex_m_rd         = 5'd0;
        bus.ex_m_mem_read   = 1'b0;
    endtask

    // counted=1 marks a cycle the perf counter must add after this edge
    task automatic chk(input string tag, input logic [4:0] v, input logic counted);
        exp_t e, got;
        logic [31:0] obs_sc;
        logic [4:0]  obs_v;
        e.v = v;
`ifdef HAZARD_PERF_CNT_EN
        e.sc = reset ? 32'd0 : 32'(exp_sc);
`else
        e.sc = 32'd0;
`endif
        q.push_back(e);
        #1;
        got    = q.pop_front();
        obs_v  = {bus.pc_write, bus.if_id_write, bus.id_ex_bubble, bus.if_id_flush, bus.halted};
        obs_sc = bus.stall_count;
        checks++;
        assert (obs_v === got.v) else begin
            errors++;
            $error("FAIL %s ctl observed=%b expected=%b", tag, obs_v, got.v);
        end
        checks++;
        assert (obs_sc === got.sc) else begin
            errors++;
            $error("FAIL %s stall_count observed=%0d expected=%0d", tag, obs_sc, got.sc);
        end
        if (reset) exp_sc = 0;
        else if (counted) exp_sc++;
    endtask

    task automatic lw_beq3();
        clr();
        bus.id_ex_mem_read = 1'b1; bus.id_ex_reg_write = 1'b1; bus.id_ex_rt = 5'd3;
        bus.if_id_is_branch = 1'b1; bus.branch_taken = 1'b1; bus.if_id_uses_rt = 1'b1;
        bus.if_id_rs = 5'd3; bus.if_id_rt = 5'd0;
    endtask

    initial begin
        reset = 1'b1; bus.enable = 1'b1; clr();

        @(negedge clk); chk("reset0", V_RST, 1'b0);
        @(negedge clk); chk("reset1", V_RST, 1'b0);
        reset = 1'b0;
        @(negedge clk); clr(); chk("idle", V_RUN, 1'b0);

        // lw $2 in EX, add reads $2
        @(negedge clk); clr();
        bus.id_ex_mem_read = 1'b1; bus.id_ex_reg_write = 1'b1; bus.id_ex_rt = 5'd2;
        bus.if_id_rs = 5'd2; bus.if_id_rt = 5'd9; bus.if_id_uses_rt = 1'b1;
        chk("lw_use", V_STALL, 1'b1);
        @(negedge clk); clr(); bus.if_id_rs = 5'd2; chk("lw_use_resume", V_RUN, 1'b0);

        // $0 load never stalls; unread rt never stalls
        @(negedge clk); clr();
        bus.id_ex_mem_read = 1'b1; bus.id_ex_rt = 5'd0; bus.if_id_uses_rt = 1'b1;
        chk("dest_zero", V_RUN, 1'b0);
        @(negedge clk); clr();
        bus.id_ex_mem_read = 1'b1; bus.id_ex_rt = 5'd7; bus.if_id_rs = 5'd1; bus.if_id_rt = 5'd7;
        chk("rt_unused", V_RUN, 1'b0);
        bus.if_id_uses_rt = 1'b1;
        @(negedge clk); chk("rt_used", V_STALL, 1'b1);

        // lw $3 then beq $3,$0: two stalls, then taken flush
        @(negedge clk); lw_beq3(); chk("beq_lw_c0", V_STALL, 1'b1);
        @(negedge clk); chk("beq_lw_c1", V_STALL, 1'b1);
        @(negedge clk); clr();
        bus.if_id_is_branch = 1'b1; bus.branch_taken = 1'b1; bus.if_id_rs = 5'd3;
        chk("beq_taken", V_FLUSH, 1'b0);
        @(negedge clk); clr(); chk("after_flush", V_RUN, 1'b0);

        // add $4 then bne $4: one stall, then flush
        @(negedge clk); clr();
        bus.id_ex_reg_write = 1'b1; bus.id_ex_rd_dst = 5'd4;
        bus.if_id_is_branch = 1'b1; bus.branch_taken = 1'b1; bus.if_id_rs = 5'd4; bus.if_id_uses_rt = 1'b1;
        chk("bne_alu", V_STALL, 1'b1);
        @(negedge clk); clr();
        bus.if_id_is_branch = 1'b1; bus.branch_taken = 1'b1; bus.if_id_rs = 5'd4; bus.ex_m_rd = 5'd4;
        chk("bne_taken", V_FLUSH, 1'b0);
        @(negedge clk); clr(); bus.if_id_is_branch = 1'b1; chk("br_not_taken", V_RUN, 1'b0);

        // branch vs load in EX/MEM stalls; non-branch consumers do not
        @(negedge clk); clr();
        bus.if_id_is_branch = 1'b1; bus.ex_m_mem_read = 1'b1; bus.ex_m_rd = 5'd6;
        bus.if_id_rs = 5'd1; bus.if_id_rt = 5'd6; bus.if_id_uses_rt = 1'b1;
        chk("br_mem_load", V_STALL, 1'b1);
        bus.if_id_is_branch = 1'b0;
        @(negedge clk); chk("alu_mem_load", V_RUN, 1'b0);
        @(negedge clk); clr();
        bus.id_ex_reg_write = 1'b1; bus.id_ex_rd_dst = 5'd5; bus.if_id_rs = 5'd5;
        chk("alu_ex_alu", V_RUN, 1'b0);
        @(negedge clk); clr(); bus.branch_taken = 1'b1; chk("taken_no_branch", V_RUN, 1'b0);

        // enable low freezes everything
        @(negedge clk); lw_beq3(); bus.if_id_is_branch = 1'b0; bus.enable = 1'b0;
        chk("enable_off", V_OFF, 1'b0);
        bus.enable = 1'b1;
        @(negedge clk); chk("enable_on", V_STALL, 1'b1);

        // reset during STALL
        @(negedge clk); lw_beq3(); chk("stall_enter", V_STALL, 1'b1);
        @(negedge clk); reset = 1'b1; chk("reset_in_stall", V_RST, 1'b0);
        @(negedge clk); reset = 1'b0; clr(); chk("post_reset_stall", V_RUN, 1'b0);

        // halt blocked by hazard, then drain interrupted by reset
        @(negedge clk); clr();
        bus.if_id_halt = 1'b1; bus.id_ex_mem_read = 1'b1; bus.id_ex_rt = 5'd2; bus.if_id_rs = 5'd2;
        chk("halt_hazard", V_STALL, 1'b1);
        @(negedge clk); clr(); bus.if_id_halt = 1'b1; chk("halt_a", V_HFL, 1'b0);
        @(negedge clk); clr(); chk("drain_a1", V_DRAIN, 1'b0);
        @(negedge clk); reset = 1'b1; chk("reset_in_drain", V_RST, 1'b0);
        @(negedge clk); reset = 1'b0; chk("post_reset_drain", V_RUN, 1'b0);

        // full drain with one frozen cycle: halted on the fifth cycle after halt
        @(negedge clk); clr(); bus.if_id_halt = 1'b1; chk("halt_b", V_HFL, 1'b0);
        @(negedge clk); clr(); chk("drain_b1", V_DRAIN, 1'b0);
        @(negedge clk); bus.enable = 1'b0; chk("drain_frozen", V_OFF, 1'b0);
        @(negedge clk); bus.enable = 1'b1; chk("drain_b2", V_DRAIN, 1'b0);
        @(negedge clk); chk("drain_b3", V_DRAIN, 1'b0);
        @(negedge clk); chk("halted", V_HALTED, 1'b0);
        @(negedge clk); lw_beq3(); bus.if_id_halt = 1'b1; chk("halted_hold", V_HALTED, 1'b0);
        @(negedge clk); bus.enable = 1'b0; chk("halted_off", V_OFFH, 1'b0);
        bus.enable = 1'b1;
        @(negedge clk); reset = 1'b1; chk("reset_halted", V_RST, 1'b0);
        @(negedge clk); reset = 1'b0; clr(); chk("post_reset_halt", V_RUN, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_hazard_sequencer.md
ID_HAZARD_SEQUENCER -- requirements
Module: id_hazard_sequencer

Interface
REQ-001 Parameter DRAIN_CYCLES, default 4, cycles between halt decode and halted assertion.
REQ-002 Parameter CNT_W, default 32, width of stall performance counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  global run enable; 0 freezes sequencer and pipeline front end.
REQ-006 if_id_rs, if_id_rt  in  5 each  ID-stage source registers.
REQ-007 if_id_is_branch  in  1  ID holds branch resolved in ID; if_id_uses_rt  in  1  instruction reads rt.
REQ-008 if_id_halt  in  1  ID holds halt instruction.
REQ-009 branch_taken  in  1  ID comparator result, valid with if_id_is_branch.
REQ-010 id_ex_rt, id_ex_rd_dst  in  5 each; id_ex_mem_read, id_ex_reg_write  in  1 each  EX-stage producer info.
REQ-011 ex_m_rd  in  5; ex_m_mem_read  in  1  EX/MEM producer info.
REQ-012 pc_write, if_id_write  out  1 each  PC and IF/ID load enables.
REQ-013 id_ex_bubble  out  1  zeroes ID/EX control fields; if_id_flush  out  1  clears IF/ID.
REQ-014 halted  out  1  pipeline drained; stall_count  out  CNT_W  stall cycles (macro-gated).

Function
REQ-015 States: RUN, STALL, DRAIN, HALTED; encoding 2 bits.
REQ-016 Register 0 never matches (hazard compare ignores dest 5'd0).
REQ-017 Hazard need (combinational, RUN only): 2 if branch and id_ex_mem_read and id_ex_rt matches rs/rt(used); else 1 if id_ex_mem_read and id_ex_rt matches rs/rt(used); else 1 if branch and id_ex_reg_write and id_ex_rd_dst matches; else 1 if branch and ex_m_mem_read and ex_m_rd matches; else 0.
REQ-018 Stall cycle outputs: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0.
REQ-019 RUN, need=0: pc_write=1, if_id_write=1, bubble=0; if_id_flush=branch_taken&&if_id_is_branch, same cycle.
REQ-020 RUN, need=1: stall this cycle, stay RUN (hazard re-evaluated next cycle).
REQ-021 RUN, need=2: stall this cycle, go STALL with cnt=1; STALL stalls, decrements, returns RUN at cnt=0.
REQ-022 Stall beats branch flush and halt: taken branch or halt with need>0 produces no flush/halt that cycle.
REQ-023 RUN, if_id_halt, need=0: pc_write=0, if_id_flush=1, go DRAIN with cnt=DRAIN_CYCLES-1.
REQ-024 DRAIN: pc_write=0, if_id_write=0, bubble=1; decrement; at cnt=0 go HALTED.
REQ-025 HALTED: halted=1, pc_write=0, if_id_write=0, bubble=1; exits only by reset.
REQ-026 enable=0: state/counters hold, pc_write=0, if_id_write=0, bubble=0, flush=0; halted unchanged.

Reset
REQ-027 reset=1 on edge: state=RUN, cnt=0, stall_count=0.
REQ-028 While reset high: pc_write=0, if_id_write=0, bubble=1, flush=0, halted=0; overrides mid-stall/mid-drain.

Configuration
REQ-029 Macro HAZARD_PERF_CNT_EN defined: stall_count increments each enabled cycle with stall outputs (RUN stall, STALL, excluding DRAIN/HALTED), saturating at all-ones.
REQ-030 Macro undefined: counter not built, stall_count tied 0.

Structure
REQ-031 Shared package holds state encoding constants and DRAIN_CYCLES default.
REQ-032 One sub-module hazard_need_calc computes need (2 bits), purely combinational.

Verification
REQ-033 lw $2 in EX, add using $2 in ID -> one stall cycle (pc_write=0, bubble=1), then RUN, stall_count=1.
REQ-034 lw $3 in EX, beq $3,$0 in ID -> two stall cycles via STALL, then branch resolves; taken -> if_id_flush=1 one cycle.
REQ-035 add $4 in EX, bne $4 in ID -> one stall; taken branch, no hazard -> flush only, pc_write=1.
REQ-036 halt in ID, DRAIN_CYCLES=4 -> halted=1 exactly 4 cycles later, pc_write=0 throughout; enable=0 mid-drain extends by held cycles.
REQ-037 reset asserted during STALL and DRAIN -> next cycle RUN, halted=0, stall_count=0; dest $0 load -> no stall.
